// File: rtl/gpio_pkg.sv
// gpio_pkg: shared definitions for the gpio_ctrl APB GPIO controller.
// Holds the register offset map, the last valid offset, the decoded
// register enumeration and a helper that maps a 12-bit window offset
// onto that enumeration (misaligned or out-of-range offsets decode to
// REG_NONE).
package gpio_pkg;

  localparam logic [11:0] GPIO_DIR_OFS     = 12'h000;
  localparam logic [11:0] GPIO_IN_OFS      = 12'h004;
  localparam logic [11:0] GPIO_OUT_OFS     = 12'h008;
  localparam logic [11:0] GPIO_OUT_SET_OFS = 12'h00C;
  localparam logic [11:0] GPIO_OUT_CLR_OFS = 12'h010;
  localparam logic [11:0] GPIO_RISE_EN_OFS = 12'h014;
  localparam logic [11:0] GPIO_FALL_EN_OFS = 12'h018;
  localparam logic [11:0] GPIO_STATUS_OFS  = 12'h01C;
  localparam logic [11:0] GPIO_LAST_OFS    = GPIO_STATUS_OFS;

  typedef enum logic [3:0] {
    REG_DIR,
    REG_IN,
    REG_OUT,
    REG_OUT_SET,
    REG_OUT_CLR,
    REG_RISE_EN,
    REG_FALL_EN,
    REG_STATUS,
    REG_NONE
  } gpio_reg_e;

  function automatic gpio_reg_e gpio_decode(input logic [11:0] ofs);
    gpio_reg_e r;
    case (ofs)
      GPIO_DIR_OFS:     r = REG_DIR;
      GPIO_IN_OFS:      r = REG_IN;
      GPIO_OUT_OFS:     r = REG_OUT;
      GPIO_OUT_SET_OFS: r = REG_OUT_SET;
      GPIO_OUT_CLR_OFS: r = REG_OUT_CLR;
      GPIO_RISE_EN_OFS: r = REG_RISE_EN;
      GPIO_FALL_EN_OFS: r = REG_FALL_EN;
      GPIO_STATUS_OFS:  r = REG_STATUS;
      default:          r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: multi-flop input synchroniser plus one-cycle history
// register, producing per-pin rising and falling edge strobes.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   din  [WIDTH]   - asynchronous pad inputs
//   sync [WIDTH]   - synchronised inputs (last chain stage)
//   rise [WIDTH]   - sync & ~prev
//   fall [WIDTH]   - ~sync & prev
module gpio_sync_edge #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] sync_p [STAGES];
  logic [WIDTH-1:0] prev_p;

  // Synchroniser chain and history register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) sync_p[i] <= '0;
      prev_p <= '0;
    end else begin
      sync_p[0] <= din;
      for (int i = 1; i < STAGES; i++) sync_p[i] <= sync_p[i-1];
      prev_p <= sync_p[STAGES-1];
    end
  end

  assign sync = sync_p[STAGES-1];
  assign rise = sync & ~prev_p;
  assign fall = ~sync & prev_p;

endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: APB GPIO controller with configurable pin count, input
// synchroniser, atomic output set/clear and per-pin edge interrupts.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   PSEL/PENABLE/PWRITE/PADDR - APB request, PWDATA write data
//   PRDATA/PREADY/PSLVERR     - APB response (zero wait states)
//   gpio_in  [GPIO_WIDTH]     - asynchronous pad inputs
//   gpio_out [GPIO_WIDTH]     - OUT register
//   gpio_en  [GPIO_WIDTH]     - DIR register, 1 = drive
//   irq                       - registered OR of pending enabled STATUS bits
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int                    GPIO_WIDTH  = 32,
  parameter int                    SYNC_STAGES = 2,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 'h9300_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]           PWDATA,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_en,
  output logic                  irq
);

  logic [GPIO_WIDTH-1:0] dir_q;
  logic [GPIO_WIDTH-1:0] out_q;
  logic [GPIO_WIDTH-1:0] rise_en_q;
  logic [GPIO_WIDTH-1:0] fall_en_q;
  logic [GPIO_WIDTH-1:0] status_q;
  logic                  irq_q;

  logic [GPIO_WIDTH-1:0] sync;
  logic [GPIO_WIDTH-1:0] rise;
  logic [GPIO_WIDTH-1:0] fall;

  logic                  access;
  logic                  page_ok;
  logic                  addr_err;
  logic                  wr_en;
  gpio_reg_e             reg_sel;
  logic [GPIO_WIDTH-1:0] wdata;
  logic [GPIO_WIDTH-1:0] set_ev;
  logic [GPIO_WIDTH-1:0] w1c;
  logic [31:0]           rdata;

  // Pad-width register value zero-extended onto the 32-bit bus.
  function automatic logic [31:0] zext(input logic [GPIO_WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[GPIO_WIDTH-1:0] = v;
    return r;
  endfunction

  gpio_sync_edge #(
    .WIDTH  (GPIO_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (gpio_in),
    .sync (sync),
    .rise (rise),
    .fall (fall)
  );

  assign access   = PSEL & PENABLE;
  assign reg_sel  = gpio_decode(PADDR[11:0]);
  assign page_ok  = (PADDR[ADDR_WIDTH-1:12] == BASE_ADDR[ADDR_WIDTH-1:12]);
  assign addr_err = (reg_sel == REG_NONE) | ~page_ok;
  assign wr_en    = access & PWRITE & ~addr_err;
  assign wdata    = PWDATA[GPIO_WIDTH-1:0];

  // Edge events take priority over a same-cycle W1C on the same bit,
  // so an edge arriving while software clears is never lost.
  assign set_ev = (rise & rise_en_q) | (fall & fall_en_q);
  assign w1c    = (wr_en && reg_sel == REG_STATUS) ? wdata : '0;

  // Register file, STATUS and irq flop
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q     <= '0;
      out_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      if (wr_en) begin
        case (reg_sel)
          REG_DIR:     dir_q     <= wdata;
          REG_OUT:     out_q     <= wdata;
          REG_OUT_SET: out_q     <= out_q | wdata;
          REG_OUT_CLR: out_q     <= out_q & ~wdata;
          REG_RISE_EN: rise_en_q <= wdata;
          REG_FALL_EN: fall_en_q <= wdata;
          default:     ;
        endcase
      end
      status_q <= (status_q & ~w1c) | set_ev;
      irq_q    <= |(status_q & (rise_en_q | fall_en_q));
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_DIR:     rdata = zext(dir_q);
      REG_IN:      rdata = zext(sync);
      REG_OUT:     rdata = zext(out_q);
      REG_RISE_EN: rdata = zext(rise_en_q);
      REG_FALL_EN: rdata = zext(fall_en_q);
      REG_STATUS:  rdata = zext(status_q);
      default:     rdata = '0;
    endcase
  end

  // Response is driven only in a legal access phase and is forced low
  // while reset is asserted so an aborted transfer returns nothing.
  assign PREADY  = access;
  assign PSLVERR = access & addr_err & ~rst;
  assign PRDATA  = (access && !addr_err && !rst) ? rdata : 32'h0;

  assign gpio_out = out_q;
  assign gpio_en  = dir_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: self-checking bench for gpio_ctrl. Instance A uses the
// default 32-pin configuration and is tracked by a history-based model;
// instance B uses 8 pins for width-masking checks.
module tb_gpio_ctrl;

  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel_a = 1'b0;
  logic        psel_b = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] gin = '0;
  logic [7:0]  gin_b = '0;

  logic [31:0] prdata_a, prdata_b;
  logic        pready_a, pready_b, slverr_a, slverr_b;
  logic [31:0] gout_a, gen_a;
  logic [7:0]  gout_b, gen_b;
  logic        irq_a, irq_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gpio_ctrl u_a (
    .clk(clk), .rst(rst), .PSEL(psel_a), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata_a), .PREADY(pready_a),
    .PSLVERR(slverr_a), .gpio_in(gin), .gpio_out(gout_a), .gpio_en(gen_a),
    .irq(irq_a)
  );

  gpio_ctrl #(.GPIO_WIDTH(8)) u_b (
    .clk(clk), .rst(rst), .PSEL(psel_b), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata_b), .PREADY(pready_b),
    .PSLVERR(slverr_b), .gpio_in(gin_b), .gpio_out(gout_b), .gpio_en(gen_b),
    .irq(irq_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model for instance A ----------------
  // hist[k] is the pad value sampled k+1 edges ago; the visible IN value
  // is hist[SS-1] and the one-cycle-older value is hist[SS].
  logic [31:0] hist [0:SS];
  logic [31:0] m_dir = '0, m_out = '0, m_re = '0, m_fe = '0, m_st = '0;
  logic        m_irq = 1'b0;
  logic [31:0] m_ev, m_w1c;
  logic        m_wr;

  function automatic bit m_err(input logic [31:0] a);
    return (a[11:0] > 12'h01C) || (a[1:0] != 2'b00) || (a[31:12] != 20'h93000);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (m_err(a)) return 32'h0;
    case (a[4:2])
      3'd0: return m_dir;
      3'd1: return hist[SS-1];
      3'd2: return m_out;
      3'd5: return m_re;
      3'd6: return m_fe;
      3'd7: return m_st;
      default: return 32'h0;
    endcase
  endfunction

  initial for (int k = 0; k <= SS; k++) hist[k] = '0;

  assign m_ev  = (hist[SS-1] & ~hist[SS] & m_re) | (~hist[SS-1] & hist[SS] & m_fe);
  assign m_wr  = psel_a & PENABLE & PWRITE & !m_err(PADDR);
  assign m_w1c = (m_wr && PADDR[4:2] == 3'd7) ? PWDATA : 32'h0;

  always @(posedge clk) begin
    if (rst) begin
      m_dir <= '0; m_out <= '0; m_re <= '0; m_fe <= '0; m_st <= '0; m_irq <= 1'b0;
      for (int k = 0; k <= SS; k++) hist[k] <= '0;
    end else begin
      if (m_wr) begin
        case (PADDR[4:2])
          3'd0: m_dir <= PWDATA;
          3'd2: m_out <= PWDATA;
          3'd3: m_out <= m_out | PWDATA;
          3'd4: m_out <= m_out & ~PWDATA;
          3'd5: m_re  <= PWDATA;
          3'd6: m_fe  <= PWDATA;
          default: ;
        endcase
      end
      m_st  <= (m_st & ~m_w1c) | m_ev;
      m_irq <= |(m_st & (m_re | m_fe));
      hist[0] <= gin;
      for (int k = 1; k <= SS; k++) hist[k] <= hist[k-1];
    end
  end

  bit mon_on = 1'b0;
  always @(negedge clk) begin
    if (mon_on) begin
      chk("mon_gpio_out", gout_a, m_out);
      chk("mon_gpio_en", gen_a, m_dir);
      chk("mon_irq", {31'b0, irq_a}, {31'b0, m_irq});
    end
  end

  // ---------------- APB transfer ----------------
  task automatic apb(input bit b, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er);
    @(negedge clk);
    psel_a = !b; psel_b = b; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
    @(negedge clk);
    PENABLE = 1'b1;
    #1;
    rd = b ? prdata_b : prdata_a;
    er = b ? slverr_b : slverr_a;
    chk("pready", {31'b0, (b ? pready_b : pready_a)}, 32'h1);
    @(posedge clk);
    #1;
    psel_a = 1'b0; psel_b = 1'b0; PENABLE = 1'b0;
  endtask

  typedef struct {
    bit          b;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          err;
  } vec_t;

  localparam logic [31:0] B = 32'h9300_0000;
  vec_t tbl [28];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          timeout_guard;

    tbl[0]  = '{0, 0, B + 32'h00, 32'h0, 0};
    tbl[1]  = '{0, 0, B + 32'h04, 32'h1234_5678, 0};
    tbl[2]  = '{0, 0, B + 32'h08, 32'h0, 0};
    tbl[3]  = '{0, 0, B + 32'h0C, 32'h0, 0};
    tbl[4]  = '{0, 0, B + 32'h10, 32'h0, 0};
    tbl[5]  = '{0, 0, B + 32'h14, 32'h0, 0};
    tbl[6]  = '{0, 0, B + 32'h18, 32'h0, 0};
    tbl[7]  = '{0, 0, B + 32'h1C, 32'h0, 0};
    tbl[8]  = '{0, 1, B + 32'h00, 32'hFFFF_FFFF, 0};
    tbl[9]  = '{0, 1, B + 32'h08, 32'h0000_00F0, 0};
    tbl[10] = '{0, 1, B + 32'h0C, 32'h0000_000F, 0};
    tbl[11] = '{0, 1, B + 32'h10, 32'h0000_0030, 0};
    tbl[12] = '{0, 0, B + 32'h08, 32'h0000_00CF, 0};
    tbl[13] = '{0, 0, B + 32'h0C, 32'h0, 0};
    tbl[14] = '{0, 0, B + 32'h00, 32'hFFFF_FFFF, 0};
    tbl[15] = '{0, 0, B + 32'h20, 32'h0, 1};
    tbl[16] = '{0, 0, 32'h9300_1000, 32'h0, 1};
    tbl[17] = '{0, 1, B + 32'h20, 32'h0000_00FF, 1};
    tbl[18] = '{0, 1, 32'h9300_1008, 32'h0, 1};
    tbl[19] = '{0, 1, B + 32'h06, 32'h0, 1};
    tbl[20] = '{0, 0, B + 32'h02, 32'h0, 1};
    tbl[21] = '{0, 0, B + 32'h08, 32'h0000_00CF, 0};
    tbl[22] = '{0, 1, B + 32'h04, 32'h0000_FFFF, 0};
    tbl[23] = '{0, 0, B + 32'h04, 32'h1234_5678, 0};
    tbl[24] = '{1, 0, B + 32'h00, 32'h0, 0};
    tbl[25] = '{1, 1, B + 32'h08, 32'hFFFF_FFFF, 0};
    tbl[26] = '{1, 0, B + 32'h08, 32'h0000_00FF, 0};
    tbl[27] = '{1, 0, B + 32'h1C, 32'h0, 0};

    // reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_gpio_out", gout_a, 32'h0);
    chk("rst_gpio_en", gen_a, 32'h0);
    chk("rst_irq", {31'b0, irq_a}, 32'h0);
    chk("rst_prdata_idle", prdata_a, 32'h0);
    mon_on = 1'b1;

    // pads high with enables still 0: no STATUS expected
    gin = 32'h1234_5678;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 28; i++) begin
      apb(tbl[i].b, tbl[i].wr, tbl[i].addr, tbl[i].data, rd, er);
      chk($sformatf("tbl%0d_err", i), {31'b0, er}, {31'b0, tbl[i].err});
      if (!tbl[i].wr) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].data);
    end
    chk("gpio_en_all", gen_a, 32'hFFFF_FFFF);
    chk("gpio_out_cf", gout_a, 32'h0000_00CF);
    chk("b_gpio_out", {24'b0, gout_b}, 32'h0000_00FF);

    // rise edge latency and irq timing
    apb(0, 1, B + 32'h14, 32'h0, rd, er);
    apb(0, 1, B + 32'h18, 32'h0, rd, er);
    gin = 32'h0;
    repeat (4) @(negedge clk);
    apb(0, 1, B + 32'h1C, 32'hFFFF_FFFF, rd, er);
    apb(0, 1, B + 32'h14, 32'h1, rd, er);
    repeat (2) @(negedge clk);
    chk("irq_idle", {31'b0, irq_a}, 32'h0);
    gin[0] = 1'b1;                       // sampled at edge N
    @(negedge clk);                      // after N
    psel_a = 1'b1; PWRITE = 1'b0; PADDR = B + 32'h04; PENABLE = 1'b0;
    @(negedge clk);                      // after N+1
    PENABLE = 1'b1;
    #1;
    chk("in_lat_n1", prdata_a & 32'h1, 32'h1);
    chk("irq_n1", {31'b0, irq_a}, 32'h0);
    @(posedge clk);
    #1;
    psel_a = 1'b0; PENABLE = 1'b0;
    @(negedge clk);                      // after N+2
    chk("irq_n2", {31'b0, irq_a}, 32'h0);
    psel_a = 1'b1; PADDR = B + 32'h1C;
    @(negedge clk);                      // after N+3
    chk("irq_n3", {31'b0, irq_a}, 32'h1);
    PENABLE = 1'b1;
    #1;
    chk("status_rise", prdata_a, 32'h1);
    @(posedge clk);
    #1;
    psel_a = 1'b0; PENABLE = 1'b0;
    apb(0, 1, B + 32'h1C, 32'h1, rd, er);
    chk("irq_after_w1c_edge", {31'b0, irq_a}, 32'h1);
    @(posedge clk);
    #1;
    chk("irq_dropped", {31'b0, irq_a}, 32'h0);

    // set beats same-cycle W1C
    apb(0, 1, B + 32'h18, 32'h8, rd, er);
    gin[3] = 1'b1;
    repeat (4) @(negedge clk);
    chk("status3_pre", prdata_a, 32'h0);
    @(negedge clk);
    gin[3] = 1'b0;                       // fall reaches STATUS on the W1C edge
    apb(0, 1, B + 32'h1C, 32'h8, rd, er);
    apb(0, 0, B + 32'h1C, 32'h0, rd, er);
    chk("set_wins", rd & 32'h8, 32'h8);
    apb(0, 1, B + 32'h1C, 32'hFFFF_FFFF, rd, er);
    apb(0, 0, B + 32'h1C, 32'h0, rd, er);
    chk("status_cleared", rd, 32'h0);

    // reset during a write access phase
    apb(0, 1, B + 32'h00, 32'hFFFF_FFFF, rd, er);
    @(negedge clk);
    psel_a = 1'b1; PWRITE = 1'b1; PADDR = B + 32'h08; PWDATA = 32'h5; PENABLE = 1'b0;
    @(negedge clk);
    PENABLE = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; psel_a = 1'b0; PENABLE = 1'b0;
    chk("rstmid_gpio_out", gout_a, 32'h0);
    chk("rstmid_gpio_en", gen_a, 32'h0);
    chk("rstmid_irq", {31'b0, irq_a}, 32'h0);
    chk("rstmid_b_out", {24'b0, gout_b}, 32'h0);
    apb(0, 0, B + 32'h08, 32'h0, rd, er);
    chk("rstmid_out_rd", rd, 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, d, exp_rd;
      bit          w, bad;
      if ($urandom_range(0, 1) == 1) gin = gin ^ (32'h1 << $urandom_range(0, 31)) ^
                                           ($urandom_range(0, 3) == 0 ? $urandom : 32'h0);
      a   = B + ($urandom_range(0, 7) << 2);
      bad = ($urandom_range(0, 9) == 0);
      if (bad) a = ($urandom_range(0, 1) == 1) ? (B + 32'h24) : (a + 32'h1000);
      w   = ($urandom_range(0, 1) == 1);
      d   = $urandom;
      if (a[4:2] == 3'd7 && $urandom_range(0, 1) == 1) d = 32'h0;
      exp_rd = 32'h0;
      @(negedge clk);
      psel_a = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
      @(negedge clk);
      PENABLE = 1'b1;
      #1;
      exp_rd = w ? 32'h0 : m_read(a);
      chk($sformatf("rnd%0d_err", i), {31'b0, slverr_a}, {31'b0, m_err(a)});
      if (!w) chk($sformatf("rnd%0d_rdata", i), prdata_a, exp_rd);
      @(posedge clk);
      #1;
      psel_a = 1'b0; PENABLE = 1'b0;
      timeout_guard = $urandom_range(0, 2);
      repeat (timeout_guard) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gpio_ctrl.md
# gpio_ctrl

Parametrised APB GPIO controller, the next generation of the team's `gpio` peripheral. It adds configurable pin count, an input synchroniser, atomic set/clear of outputs, and per-pin rising/falling-edge interrupts with a combined interrupt line. It sits on the APB peripheral bus at `BASE_ADDR`, drives the pad-level `gpio_out`/`gpio_en`, and feeds `irq` to the interrupt controller.

## Interface
- `GPIO_WIDTH`, 32: number of pins, 1..32.
- `SYNC_STAGES`, 2: flops in the input synchroniser, 2..4.
- `ADDR_WIDTH`, 32: APB address width.
- `BASE_ADDR`, 'h9300_0000: base of the 4 KiB register window.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `PSEL`, `PENABLE`, `PWRITE` in 1: APB control.
- `PADDR` in ADDR_WIDTH: APB address.
- `PWDATA` in 32: APB write data.
- `PRDATA` out 32: APB read data.
- `PREADY` out 1: APB ready.
- `PSLVERR` out 1: APB error.
- `gpio_in` in GPIO_WIDTH: asynchronous pad inputs.
- `gpio_out` out GPIO_WIDTH: output values (the OUT register).
- `gpio_en` out GPIO_WIDTH: output enables (the DIR register); 1 = drive.
- `irq` out 1: registered OR of `STATUS & (RISE_EN | FALL_EN)`.

## Operation
Register map (offset from `BASE_ADDR`, word aligned):
- 0x00 DIR, RW. Drives `gpio_en`.
- 0x04 IN, RO. Synchronised `gpio_in`.
- 0x08 OUT, RW. Drives `gpio_out`.
- 0x0C OUT_SET, WO. Write-1-sets OUT bits; reads 0.
- 0x10 OUT_CLR, WO. Write-1-clears OUT bits; reads 0.
- 0x14 RISE_EN, RW.
- 0x18 FALL_EN, RW.
- 0x1C STATUS, RW1C. Edge-event flags.

Access and bit rules:
- Bits [31:GPIO_WIDTH] are ignored on write and read 0.
- Writes to IN are ignored, with no error.
- `PSLVERR` = 1 in the access phase if `PADDR[11:0]` > 0x1C, `PADDR[1:0]` ≠ 0, or `PADDR[ADDR_WIDTH-1:12]` ≠ `BASE_ADDR[ADDR_WIDTH-1:12]`.
- An errored write changes nothing. An errored read returns 0.

Synchroniser and edge detect:
- `gpio_in` passes through `SYNC_STAGES` flops to give `sync`.
- A `prev` register holds `sync` delayed by one cycle.
- rise = `sync & ~prev`; fall = `~sync & prev`.
- STATUS bit i sets when (rise_i & RISE_EN_i) | (fall_i & FALL_EN_i).

STATUS conflicts:
- W1C clears the written bits.
- If a set event and a W1C hit the same bit in the same cycle, the set wins and the bit stays 1.

Reset values:
- All registers, synchroniser flops, `prev`, `gpio_out`, `gpio_en`, `irq` and `PSLVERR` reset to 0.
- `PRDATA` resets to 0.
- `PREADY` is combinational and is not held by reset.
- Because enables reset to 0, a pad held high through reset produces no STATUS bit.
- A `rst` asserted mid-transfer aborts the transfer. No register write occurs in that cycle, even if it is the access phase.

## Timing
- Zero wait states: `PREADY` = `PSEL & PENABLE`.
- Writes commit on the rising edge that ends the access phase (`PSEL & PENABLE & PWRITE`). The new `gpio_out`/`gpio_en` are visible the cycle after.
- `PRDATA` and `PSLVERR` are combinational from registers and `PADDR` during the access phase. `PRDATA` is 0 outside the access phase.
- Input latency: a `gpio_in` change sampled at edge N appears in IN after edge N+SYNC_STAGES-1.
- STATUS sets at edge N+SYNC_STAGES, and `irq` rises at edge N+SYNC_STAGES+1.
- Clearing the last pending STATUS bit drops `irq` one edge after the STATUS write.
- Pulses shorter than one clock may be missed; this is by design.
- Back-to-back transfers, with setup immediately following access, are supported.

## Structure
- Package `gpio_pkg`:
  - register offset constants (`GPIO_DIR_OFS` … `GPIO_STATUS_OFS`);
  - `GPIO_LAST_OFS`;
  - a `gpio_reg_e` enum for decoded registers.
- Sub-module `gpio_sync_edge`, parameters `WIDTH` and `STAGES`. It contains the synchroniser chain and the `prev` register, and outputs `sync`, `rise` and `fall`.
- The top level contains the address decode, registers, STATUS logic and `irq` flop.

## Test plan
- Reset, then read all 8 offsets. Expected: all read 0; `gpio_out` = `gpio_en` = 0; `irq` = 0.
- Write DIR = 'hFFFF_FFFF, OUT = 'h0000_00F0, OUT_SET = 'h0000_000F, then OUT_CLR = 'h0000_0030. Expected: `gpio_en` = all 1s; `gpio_out` = 'hCF; reading OUT returns 'hCF; reading OUT_SET returns 0.
- Set RISE_EN = 'h1 and drive `gpio_in[0]` 0→1 at edge N (SYNC_STAGES = 2). Expected: IN[0] = 1 after edge N+1; STATUS = 'h1 at edge N+2; `irq` = 1 at edge N+3. Then write STATUS = 'h1: `irq` = 0 one edge later.
- Set FALL_EN bit 3, make `gpio_in[3]` fall in the same cycle as a W1C of STATUS bit 3. Expected: STATUS[3] remains 1.
- Access offset 0x20 and address 'h9300_1000. Expected: `PSLVERR` = 1, `PRDATA` = 0, no register changes. Write IN = 'hFFFF: no error, and IN still tracks the pins.
- With GPIO_WIDTH = 8, write OUT = 'hFFFF_FFFF. Expected: reads 'h0000_00FF. Also assert `rst` during an access phase: the write is dropped and all outputs are 0 after the next edge.
